// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the multi-channel clock divider
package clk_div_pkg;
   localparam int unsigned MinDiv = 2;
   typedef enum logic {IDLE, RUN} clk_div_state_e;
   function automatic int unsigned clamp_div(input int unsigned d);
      return d < MinDiv ? MinDiv : d;
   endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with period-aligned gating and ratio handshake
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int unsigned DivWidth   = 8,
   parameter int unsigned DefaultDiv = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic [DivWidth-1:0] div_i,
   input  logic                div_valid_i,
   output logic                div_ready_o,
   output logic                clk_o,
   output logic                busy_o
);
   clk_div_state_e state_q, state_d;
   logic [DivWidth-1:0] div_q, div_d, cnt_q, cnt_d, div_new, cnt_inc;
   logic clk_q, clk_d, wrap, accept;
   assign wrap        = cnt_q == div_q - DivWidth'(1);
   assign div_ready_o = (state_q == IDLE) | wrap;
   assign accept      = div_valid_i & div_ready_o;
   assign div_new     = DivWidth'(clamp_div(32'(div_i)));
   assign cnt_inc     = cnt_q + DivWidth'(1);
   assign clk_o       = clk_q;
   assign busy_o      = state_q == RUN;
   // next state: restart or stop only at a period boundary, otherwise advance the counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_inc;
      clk_d   = cnt_inc < (div_q >> 1);
      div_d   = accept ? div_new : div_q;
      if (state_q == IDLE || wrap) begin
         state_d = en_i ? RUN : IDLE;
         cnt_d   = '0;
         clk_d   = en_i;
      end
   end
   // state, counter, ratio and output clock registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         clk_q   <= 1'b0;
         div_q   <= DivWidth'(DefaultDiv);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
         div_q   <= div_d;
      end
   end
endmodule

// File: rtl/tc_clk_mux2.sv
// tc_clk_mux2: two-input clock multiplexer cell
module tc_clk_mux2 (
   input  logic clk0_i,
   input  logic clk1_i,
   input  logic clk_sel_i,
   output logic clk_o
);
   assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: independent glitch-free divided clocks from one root clock
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned NumChannels = 4,
   parameter int unsigned DivWidth    = 8,
   parameter int unsigned DefaultDiv  = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            test_mode_i,
   input  logic [NumChannels-1:0]          en_i,
   input  logic [NumChannels*DivWidth-1:0] div_i,
   input  logic [NumChannels-1:0]          div_valid_i,
   output logic [NumChannels-1:0]          div_ready_o,
   output logic [NumChannels-1:0]          clk_o,
   output logic [NumChannels-1:0]          busy_o
);
   logic [NumChannels-1:0] clk_div;
   for (genvar n = 0; n < NumChannels; n++) begin : g_ch
      clk_div_channel #(.DivWidth(DivWidth), .DefaultDiv(DefaultDiv)) u_ch (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .en_i       (en_i[n]),
         .div_i      (div_i[n*DivWidth +: DivWidth]),
         .div_valid_i(div_valid_i[n]),
         .div_ready_o(div_ready_o[n]),
         .clk_o      (clk_div[n]),
         .busy_o     (busy_o[n])
      );
      tc_clk_mux2 u_bypass (
         .clk0_i   (clk_div[n]),
         .clk1_i   (clk_i),
         .clk_sel_i(test_mode_i),
         .clk_o    (clk_o[n])
      );
   end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed table-driven bench for the multi-channel divider
module tb_clk_div_multi;
   logic clk_i = 1'b0, rst_ni = 1'b0, test_mode_i = 1'b0;
   logic [3:0] en_i = '0, div_valid_i = '0, div_ready_o, clk_o, busy_o;
   logic [31:0] div_i = '0;
   int checks = 0, errors = 0;

   typedef struct {
      logic       en;
      logic       vld;
      logic [7:0] div;
      logic       ck;
      logic       bz;
      logic       rd;
   } vec_t;
   vec_t vec[26];
   logic p1[10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
   logic p2[4]  = '{1, 0, 0, 0};

   clk_div_multi dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .test_mode_i(test_mode_i),
      .en_i       (en_i),
      .div_i      (div_i),
      .div_valid_i(div_valid_i),
      .div_ready_o(div_ready_o),
      .clk_o      (clk_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      vec[ 0] = '{1, 0, 8'd0, 1, 1, 0};
      vec[ 1] = '{1, 0, 8'd0, 0, 1, 1};
      vec[ 2] = '{1, 0, 8'd0, 1, 1, 0};
      vec[ 3] = '{1, 0, 8'd0, 0, 1, 1};
      vec[ 4] = '{1, 1, 8'd4, 1, 1, 0};
      vec[ 5] = '{1, 1, 8'd8, 1, 1, 0};
      vec[ 6] = '{1, 1, 8'd8, 0, 1, 0};
      vec[ 7] = '{1, 1, 8'd8, 0, 1, 1};
      vec[ 8] = '{1, 1, 8'd8, 1, 1, 0};
      vec[ 9] = '{1, 0, 8'd0, 1, 1, 0};
      vec[10] = '{1, 0, 8'd0, 1, 1, 0};
      vec[11] = '{1, 0, 8'd0, 1, 1, 0};
      vec[12] = '{1, 0, 8'd0, 0, 1, 0};
      vec[13] = '{1, 0, 8'd0, 0, 1, 0};
      vec[14] = '{1, 0, 8'd0, 0, 1, 0};
      vec[15] = '{1, 0, 8'd0, 0, 1, 1};
      vec[16] = '{0, 1, 8'd0, 0, 0, 1};
      vec[17] = '{1, 0, 8'd0, 1, 1, 0};
      vec[18] = '{1, 0, 8'd0, 0, 1, 1};
      vec[19] = '{0, 0, 8'd0, 0, 0, 1};
      vec[20] = '{0, 1, 8'd1, 0, 0, 1};
      vec[21] = '{1, 0, 8'd0, 1, 1, 0};
      vec[22] = '{1, 0, 8'd0, 0, 1, 1};
      vec[23] = '{1, 0, 8'd0, 1, 1, 0};
      vec[24] = '{0, 0, 8'd0, 0, 1, 1};
      vec[25] = '{0, 0, 8'd0, 0, 0, 1};
      #12;
      chk("reset_clk", 32'(clk_o), 32'h0);
      chk("reset_busy", 32'(busy_o), 32'h0);
      chk("reset_ready", 32'(div_ready_o), 32'hF);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 26; i++) begin
         en_i[0]        = vec[i].en;
         div_valid_i[0] = vec[i].vld;
         div_i[7:0]     = vec[i].div;
         @(negedge clk_i);
         chk($sformatf("vec%0d_clk", i), 32'(clk_o), {28'h0, 3'b000, vec[i].ck});
         chk($sformatf("vec%0d_busy", i), 32'(busy_o), {28'h0, 3'b000, vec[i].bz});
         chk($sformatf("vec%0d_ready", i), 32'(div_ready_o), {28'h0, 3'b111, vec[i].rd});
      end
      en_i = '0;
      div_valid_i = '0;
      div_i[15:8] = 8'd5;
      div_valid_i[1] = 1'b1;
      #1 chk("ch1_idle_ready", 32'(div_ready_o[1]), 32'h1);
      @(negedge clk_i);
      div_valid_i[1] = 1'b0;
      en_i[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         chk($sformatf("ch1_div5_c%0d", i), 32'(clk_o[1]), 32'(p1[i]));
         chk($sformatf("ch1_busy_c%0d", i), 32'(busy_o[1]), 32'h1);
      end
      en_i[1] = 1'b0;
      @(negedge clk_i);
      chk("ch1_stop_busy", 32'(busy_o[1]), 32'h0);
      chk("ch1_stop_clk", 32'(clk_o[1]), 32'h0);
      en_i[2] = 1'b1;
      div_valid_i[2] = 1'b1;
      div_i[23:16] = 8'd6;
      @(negedge clk_i);
      div_valid_i[2] = 1'b0;
      chk("ch2_c0", 32'(clk_o[2]), 32'h1);
      @(negedge clk_i);
      chk("ch2_c1", 32'(clk_o[2]), 32'h1);
      en_i[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk($sformatf("ch2_drain_c%0d", i + 2), 32'(clk_o[2]), 32'(p2[i]));
         chk($sformatf("ch2_drain_busy%0d", i + 2), 32'(busy_o[2]), 32'h1);
      end
      @(negedge clk_i);
      chk("ch2_idle_busy", 32'(busy_o[2]), 32'h0);
      chk("ch2_idle_clk", 32'(clk_o[2]), 32'h0);
      test_mode_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #2 chk("tm_high", 32'(clk_o), 32'hF);
         @(negedge clk_i);
         #2 chk("tm_low", 32'(clk_o), 32'h0);
      end
      test_mode_i = 1'b0;
      @(negedge clk_i);
      en_i[3] = 1'b1;
      div_valid_i[3] = 1'b1;
      div_i[31:24] = 8'd8;
      @(negedge clk_i);
      div_valid_i[3] = 1'b0;
      chk("ch3_div8_c0", 32'(clk_o[3]), 32'h1);
      @(posedge clk_i);
      #2 chk("ch3_div8_c1", 32'(clk_o[3]), 32'h1);
      rst_ni = 1'b0;
      #1;
      chk("arst_clk", 32'(clk_o), 32'h0);
      chk("arst_busy", 32'(busy_o), 32'h0);
      chk("arst_ready", 32'(div_ready_o), 32'hF);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_c0", 32'(clk_o[3]), 32'h1);
      @(negedge clk_i);
      chk("post_rst_c1", 32'(clk_o[3]), 32'h0);
      chk("post_rst_ready", 32'(div_ready_o[3]), 32'h1);
      @(negedge clk_i);
      chk("post_rst_c2", 32'(clk_o[3]), 32'h1);
      en_i = '0;
      repeat (3) @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel, glitch-free, run-time programmable integer clock divider for the Xilinx FPGA target.
- Generalises the plain combinational clock cells with:
  - per-channel divide ratios;
  - enable-driven clock gating that only stops at period boundaries;
  - a valid/ready handshake for ratio changes.
- Sits next to the clock cells and feeds peripheral/accelerator clock domains from one root clock.
- Every output is a register, so enables and ratio changes never glitch.

Parameters:
- NumChannels, 4, number of independent divided clock outputs.
- DivWidth, 8, width of each divide value; maximum ratio is 2**DivWidth-1.
- DefaultDiv, 2, per-channel ratio after reset; must be >= 2 and < 2**DivWidth.

Ports:
- clk_i  in  1  root clock.
- rst_ni  in  1  asynchronous active-low reset.
- test_mode_i  in  1  when high, every clk_o[n] = clk_i through a tc_clk_mux2 (bypass).
- en_i  in  NumChannels  per-channel run request.
- div_i  in  NumChannels*DivWidth  per-channel requested ratio; channel n uses slice [n*DivWidth +: DivWidth].
- div_valid_i  in  NumChannels  ratio update request.
- div_ready_o  out  NumChannels  ratio update accepted this cycle when valid & ready.
- clk_o  out  NumChannels  divided clocks.
- busy_o  out  NumChannels  channel in RUN state.

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Per-channel state is div_q, cnt_q (DivWidth bits), clk_q and an FSM with states IDLE and RUN.
- Reset values, applied asynchronously:
  - state = IDLE, cnt_q = 0, clk_q = 0, div_q = DefaultDiv;
  - clk_o = 0 (unless test_mode_i), busy_o = 0, div_ready_o = 1.
- Ratio clamp: accepted values 0 and 1 are stored as 2. A divide-by-1 path exists only through test_mode_i.
- Waveform in RUN:
  - period is div_q clk_i cycles; cnt_q runs 0..div_q-1 and then wraps to 0;
  - clk_q is high while cnt_q < (div_q>>1), low for the rest of the period;
  - div=2 gives 1 high / 1 low; div=3 gives 1 high / 2 low; div=8 gives 4 high / 4 low.
- IDLE:
  - clk_q = 0, cnt_q = 0, div_ready_o = 1;
  - an accepted ratio is written to div_q at the same edge;
  - if en_i is high at an edge: go to RUN with cnt_q = 0 and clk_q = 1 at that edge. clk_o rises one edge after en_i is sampled high.
- RUN:
  - div_ready_o = 1 only when cnt_q == div_q-1 (last cycle of the period), else 0;
  - at the wrap edge, an accepted div_i (clamped) loads div_q, and the new period starts with the new ratio (clk_q = 1);
  - if en_i is low at the wrap edge: go to IDLE, clk_q = 0.
  - en_i deasserting mid-period never truncates the period; the current period always completes.
- Simultaneous events:
  - enable drop and ratio update at the wrap edge: both take effect (IDLE, div_q updated);
  - in IDLE, en_i and an update on the same edge: RUN starts with the new ratio.
- busy_o = (state == RUN), registered.
- test_mode_i is combinational bypass only; the FSM keeps running underneath.
- Reset mid-operation clears everything immediately. A high phase may be shortened; that is acceptable because reset is asserted.
- Channels are fully independent. There is no phase alignment between channels.

Decomposition:
- Package clk_div_pkg:
  - state enum clk_div_state_e {IDLE, RUN};
  - function clamp_div(), which maps values < 2 to 2;
  - localparam MinDiv = 2.
- Sub-module clk_div_channel: one FSM, counter and handshake, with parameters DivWidth and DefaultDiv.
- Top generates NumChannels channel instances plus NumChannels tc_clk_mux2 bypass muxes.

Test Plan:
- Reset, then en_i[0]=1 with default div 2 -> clk_o[0] toggles every clk_i cycle (1 high/1 low); busy_o[0]=1 one edge after en.
- In IDLE, div_i[1]=5 with valid -> div_ready_o[1]=1, accepted; then en -> clk_o[1] period 5 cycles, 2 high / 3 low.
- Channel 0 running div 4, request div 8 mid-period -> ready only on cnt=3; first period after the update is 8 cycles (4/4); no short pulse.
- en_i[2] dropped at cnt=1 of div 6 -> period finishes (2 more high? no: 1 more high cycle at cnt=2, then 3 low); IDLE at wrap; clk_o low, busy_o=0.
- div_i=0 and div_i=1 accepted -> behaves as div 2.
- test_mode_i=1 -> all clk_o follow clk_i exactly. Async rst_ni pulse mid-high phase -> clk_o low immediately, div_q back to DefaultDiv.
